// File: rtl/openfire_fetch.sv
// -----------------------------------------------------------------------------
// openfire_fetch
//
// Instruction fetch stage of the OpenFire pipeline. Owns the program counter,
// drives a synchronous-read instruction memory and hands a registered
// instruction, its byte PC and a valid flag to decode. Branches from execute
// redirect the PC. A one-entry skid register catches the word that is already
// in flight from memory when the pipeline stalls, so nothing is lost or
// fetched twice when the stall releases.
//
// Ports:
//   clock         system clock, all state updates on the rising edge
//   reset         synchronous, active-high; wins over stall and branch_taken
//   stall         holds the PC and the decode-side outputs
//   branch_taken  redirect request from execute (ignored while stall is high)
//   pc_branch     branch target byte address; bits [1:0] are ignored
//   imem_data     memory read data, valid one cycle after imem_addr
//   imem_addr     word address to memory, combinational from pc_fetch
//   instr         registered instruction to decode
//   pc_decode     registered byte PC of instr
//   instr_valid   instr/pc_decode hold a real instruction
// -----------------------------------------------------------------------------
module openfire_fetch #(
    parameter int                  PC_WIDTH = 16,
    parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                stall,
    input  logic                branch_taken,
    input  logic [PC_WIDTH-1:0] pc_branch,
    input  logic [31:0]         imem_data,
    output logic [PC_WIDTH-3:0] imem_addr,
    output logic [31:0]         instr,
    output logic [PC_WIDTH-1:0] pc_decode,
    output logic                instr_valid
);

    logic [PC_WIDTH-1:0] pc_fetch;
    logic                req_q;
    logic [PC_WIDTH-1:0] req_pc_q;
    logic [31:0]         skid_instr;
    logic [PC_WIDTH-1:0] skid_pc;
    logic                skid_valid;

    // Targets are forced to word alignment, so the low target bits never matter.
    logic                unused_branch_bits;
    assign unused_branch_bits = ^pc_branch[1:0];

    assign imem_addr = pc_fetch[PC_WIDTH-1:2];

    always_ff @(posedge clock) begin
        if (reset) begin
            pc_fetch    <= RESET_PC;
            req_q       <= 1'b0;
            req_pc_q    <= '0;
            skid_instr  <= '0;
            skid_pc     <= '0;
            skid_valid  <= 1'b0;
            instr       <= '0;
            pc_decode   <= '0;
            instr_valid <= 1'b0;
        end else if (stall) begin
            // The memory still returns the word requested last cycle; park it
            // so it can be presented first once the stall lifts.
            req_q <= 1'b0;
            if (req_q) begin
                skid_instr <= imem_data;
                skid_pc    <= req_pc_q;
                skid_valid <= 1'b1;
            end
        end else if (branch_taken) begin
            pc_fetch    <= {pc_branch[PC_WIDTH-1:2], 2'b00};
            req_q       <= 1'b0;
            skid_valid  <= 1'b0;
            instr_valid <= 1'b0;
        end else begin
            pc_fetch <= pc_fetch + PC_WIDTH'(4);
            req_q    <= 1'b1;
            req_pc_q <= pc_fetch;
            // The skid word is older than anything on imem_data, so it goes first.
            if (skid_valid) begin
                instr       <= skid_instr;
                pc_decode   <= skid_pc;
                skid_valid  <= 1'b0;
                instr_valid <= 1'b1;
            end else if (req_q) begin
                instr       <= imem_data;
                pc_decode   <= req_pc_q;
                instr_valid <= 1'b1;
            end else begin
                instr_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_openfire_fetch.sv
module tb_openfire_fetch;

    logic        clock = 1'b0;
    logic        reset;
    logic        stall;
    logic        branch_taken;
    logic [15:0] pc_branch;

    logic [31:0] imem_data0 = '0;
    logic [31:0] imem_data1 = '0;
    logic [13:0] imem_addr0, imem_addr1;
    logic [31:0] instr0, instr1;
    logic [15:0] pc_decode0, pc_decode1;
    logic        instr_valid0, instr_valid1;

    always #5 clock = ~clock;

    openfire_fetch #(.PC_WIDTH(16), .RESET_PC(16'h0000)) dut0 (
        .clock(clock), .reset(reset), .stall(stall),
        .branch_taken(branch_taken), .pc_branch(pc_branch),
        .imem_data(imem_data0), .imem_addr(imem_addr0),
        .instr(instr0), .pc_decode(pc_decode0), .instr_valid(instr_valid0)
    );

    openfire_fetch #(.PC_WIDTH(16), .RESET_PC(16'hFFF8)) dut1 (
        .clock(clock), .reset(reset), .stall(stall),
        .branch_taken(branch_taken), .pc_branch(pc_branch),
        .imem_data(imem_data1), .imem_addr(imem_addr1),
        .instr(instr1), .pc_decode(pc_decode1), .instr_valid(instr_valid1)
    );

    // Memory contents: each word carries its own byte address.
    function automatic logic [31:0] mem_word(logic [15:0] byte_addr);
        return {16'hA5A5, byte_addr};
    endfunction

    // Synchronous-read instruction memories.
    always @(posedge clock) begin
        imem_data0 <= mem_word({imem_addr0, 2'b00});
        imem_data1 <= mem_word({imem_addr1, 2'b00});
    end

    // ---------------- reference model ----------------
    // Abstract view: the stage emits the sequential instruction stream starting
    // at a "next PC"; a reset or taken branch restarts the stream at a new PC
    // and costs one extra empty cycle; stalled cycles change nothing visible.
    typedef struct {
        logic        v;
        logic        chk;   // data outputs are known (after a first reset)
        logic        rst;
        logic [15:0] pc;
        logic [31:0] ins;
    } exp_t;

    logic [15:0] m_rpc  [2];
    logic [15:0] m_next [2];
    int          m_bub  [2];
    exp_t        m_last [2];

    exp_t q0[$];
    exp_t q1[$];

    int n_checks = 0;
    int n_fail   = 0;

    function automatic exp_t model_step(int k, logic rst, logic st, logic br, logic [15:0] tgt);
        exp_t e;
        e     = m_last[k];
        e.rst = 1'b0;
        if (rst) begin
            m_next[k] = m_rpc[k];
            m_bub[k]  = 1;
            e.v = 1'b0; e.chk = 1'b1; e.rst = 1'b1; e.pc = '0; e.ins = '0;
        end else if (st) begin
            // nothing visible changes
        end else if (br) begin
            m_next[k] = tgt & 16'hFFFC;
            m_bub[k]  = 1;
            e.v = 1'b0;
        end else if (m_bub[k] > 0) begin
            m_bub[k] = m_bub[k] - 1;
            e.v = 1'b0;
        end else begin
            e.v   = 1'b1;
            e.pc  = m_next[k];
            e.ins = mem_word(m_next[k]);
            m_next[k] = m_next[k] + 16'd4;
        end
        m_last[k] = e;
        return e;
    endfunction

    task automatic check(string name, int k, logic [31:0] got, logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s dut%0d: got %h expected %h at %0t", name, k, got, want, $time);
        end
    endtask

    // Drive one cycle of stimulus and record what must appear after its edge.
    task automatic cyc(logic rst, logic st, logic br, logic [15:0] tgt);
        reset        = rst;
        stall        = st;
        branch_taken = br;
        pc_branch    = tgt;
        q0.push_back(model_step(0, rst, st, br, tgt));
        q1.push_back(model_step(1, rst, st, br, tgt));
        @(negedge clock);
    endtask

    // ---------------- monitor ----------------
    exp_t e0, e1;

    task automatic compare_one(int k, exp_t e, logic v, logic [15:0] pc, logic [31:0] ins,
                               logic req, logic skv);
        check("instr_valid", k, {31'd0, v}, {31'd0, e.v});
        if (e.chk) begin
            check("pc_decode", k, {16'd0, pc}, {16'd0, e.pc});
            check("instr", k, ins, e.ins);
        end
        check("skid_and_req_exclusive", k, {31'd0, req & skv}, 32'd0);
        if (e.rst) check("skid_cleared_by_reset", k, {31'd0, skv}, 32'd0);
    endtask

    initial begin
        forever begin
            @(posedge clock);
            #1;
            if (q0.size() == 0 || q1.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL scoreboard_empty: got no expectation at %0t", $time);
            end else begin
                e0 = q0.pop_front();
                e1 = q1.pop_front();
                compare_one(0, e0, instr_valid0, pc_decode0, instr0, dut0.req_q, dut0.skid_valid);
                compare_one(1, e1, instr_valid1, pc_decode1, instr1, dut1.req_q, dut1.skid_valid);
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        m_rpc[0] = 16'h0000;
        m_rpc[1] = 16'hFFF8;
        for (int k = 0; k < 2; k++) begin
            m_next[k] = m_rpc[k];
            m_bub[k]  = 1;
            m_last[k] = '{v: 1'b0, chk: 1'b0, rst: 1'b0, pc: 16'h0, ins: 32'h0};
        end

        // reset, then stream start (2-edge latency, 0x0000/0x0004/0x0008; dut1 wraps)
        repeat (3) cyc(1'b1, 1'b0, 1'b0, 16'h0);
        repeat (4) cyc(1'b0, 1'b0, 1'b0, 16'h0);
        // stall 3 cycles while 0x0008 is presented, then resume without gap
        repeat (3) cyc(1'b0, 1'b1, 1'b0, 16'h0);
        repeat (2) cyc(1'b0, 1'b0, 1'b0, 16'h0);
        // branch to 0x0100 while 0x0010 is presented
        cyc(1'b0, 1'b0, 1'b1, 16'h0100);
        repeat (4) cyc(1'b0, 1'b0, 1'b0, 16'h0);
        // misaligned target is word aligned
        cyc(1'b0, 1'b0, 1'b1, 16'h0103);
        repeat (4) cyc(1'b0, 1'b0, 1'b0, 16'h0);
        // branch held during stall: ignored until stall falls
        repeat (3) cyc(1'b0, 1'b1, 1'b1, 16'h0400);
        cyc(1'b0, 1'b0, 1'b1, 16'h0400);
        repeat (4) cyc(1'b0, 1'b0, 1'b0, 16'h0);
        // stall with skid loaded, then reset for one cycle
        repeat (2) cyc(1'b0, 1'b1, 1'b0, 16'h0);
        cyc(1'b1, 1'b1, 1'b0, 16'h0);
        repeat (5) cyc(1'b0, 1'b0, 1'b0, 16'h0);
        // one-cycle stalls back to back with normal cycles
        repeat (6) begin
            cyc(1'b0, 1'b1, 1'b0, 16'h0);
            cyc(1'b0, 1'b0, 1'b0, 16'h0);
        end

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            logic r, s, b;
            logic [15:0] t;
            r = ($urandom_range(0, 99) == 0);
            s = ($urandom_range(0, 3) == 0);
            b = ($urandom_range(0, 7) == 0);
            t = 16'($urandom_range(0, 65535));
            cyc(r, s, b, t);
        end
        repeat (3) cyc(1'b0, 1'b0, 1'b0, 16'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
